// File: rtl/fastram_burst_ctrl.sv
// fastram_burst_ctrl: 68030 fast-RAM cycle controller.
// It decodes CPU cycles that hit the autoconfigured window and drives the following SRAM controls:
//   - bank/byte-lane chip selects,
//   - output enable,
//   - longword address bits [3:2],
//   - synchronous termination.
// Wait states and the number of banks are set by parameters.
// Optional 4-beat cache burst support is enabled with the macro TF_BURST_EN.
// Without TF_BURST_EN:
//   - CBACK is tied high,
//   - every cycle is a single beat,
//   - RAMA follows A[3:2].
// AS20 high acts as an asynchronous cycle abort, alongside RESET.
module fastram_burst_ctrl #(
  parameter int BANKS     = 2,
  parameter int BANK_LSB  = 21,
  parameter int WAIT_WS   = 1,
  parameter int BURST_WS  = 0,
  parameter int CACHEABLE = 1
) (
  input  logic               CLKCPU,
  input  logic               RESET,
  input  logic               AS20,
  input  logic               DS20,
  input  logic               RW20,
  input  logic [31:0]        A,
  input  logic [1:0]         SIZ,
  input  logic               DECODE,
  input  logic               CBREQ,
  output logic               CBACK,
  output logic               STERM,
  output logic               CIIN,
  output logic               INTCYCLE,
  output logic [4*BANKS-1:0] RAMCS,
  output logic               RAMOE,
  output logic [1:0]         RAMA
);

  localparam int          BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [2:0]  WAIT_LAST  = 3'(WAIT_WS - 1);
  localparam logic [2:0]  BURST_LAST = 3'(BURST_WS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ACK   = 3'd2,
`ifdef TF_BURST_EN
    S_BURST = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [3:0]         lanes_q, lanes_d;
  logic               rd_q, rd_d;
  logic [4*BANKS-1:0] ramcs_q, ramcs_d;
  logic               ramoe_q, ramoe_d;
  logic               sterm_q, sterm_d;
  logic               arst_n_s, start_s, active_s, strobe_s;
  logic [BANK_W-1:0]  bank_sel_s;
  logic               unused_s;
`ifdef TF_BURST_EN
  logic [1:0]         beat_q, beat_d;
  logic [1:0]         rama_q, rama_d;
  logic               cback_q, cback_d;
  logic               burst_req_s;
`endif

  // Byte lanes touched by a write.
  // Bit 3 is D31:24, the offset-0 byte.
  function automatic logic [3:0] lane_mask(input logic [1:0] k, input logic [1:0] siz);
    logic [2:0] n;
    logic [3:0] m;
    case (siz)
      2'b00:   n = 3'd4;
      2'b01:   n = 3'd1;
      2'b10:   n = 3'd2;
      default: n = 3'd3;
    endcase
    m = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if ((j >= int'(k)) && (j < int'(k) + int'(n))) begin
        m[3-j] = 1'b1;
      end else begin
        m[3-j] = m[3-j];
      end
    end
    return m;
  endfunction

  assign arst_n_s   = RESET & ~AS20;
  assign start_s    = ~AS20 & ~DS20 & ~DECODE;
  assign bank_sel_s = (BANKS > 1) ? A[BANK_LSB +: BANK_W] : {BANK_W{1'b0}};
  assign INTCYCLE   = AS20 | DECODE;
  assign CIIN       = (CACHEABLE != 0) ? 1'b1 : INTCYCLE;
  assign RAMCS      = ramcs_q;
  assign RAMOE      = ramoe_q;
  assign STERM      = sterm_q;
  assign unused_s   = ^{A, CBREQ};
`ifdef TF_BURST_EN
  assign burst_req_s = ~CBREQ & RW20 & (SIZ == 2'b00);
  assign CBACK       = cback_q;
  assign RAMA        = (state_q == S_IDLE) ? A[3:2] : rama_q;
`else
  assign CBACK       = 1'b1;
  assign RAMA        = A[3:2];
`endif

  // Next-state logic.
  // Decode, bank and lanes are captured only at cycle start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    lanes_d = lanes_q;
    rd_d    = rd_q;
`ifdef TF_BURST_EN
    beat_d  = beat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          bank_d  = bank_sel_s;
          rd_d    = RW20;
          lanes_d = RW20 ? 4'b1111 : lane_mask(A[1:0], SIZ);
          cnt_d   = 3'd0;
`ifdef TF_BURST_EN
          beat_d  = 2'd0;
`endif
          if (WAIT_WS == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_ACK;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_ACK: begin
`ifdef TF_BURST_EN
        if (burst_req_s) begin
          state_d = S_BURST;
          beat_d  = 2'd1;
          cnt_d   = 3'd0;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
`ifdef TF_BURST_EN
      S_BURST: begin
        if (cnt_q != BURST_LAST) begin
          cnt_d = cnt_q + 3'd1;
        end else if ((beat_q == 2'd3) || CBREQ) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 2'd1;
          cnt_d  = 3'd0;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the outputs are registered and aligned with the state.
  always_comb begin
    active_s = (state_d == S_WAIT) || (state_d == S_ACK);
    strobe_s = (state_d == S_ACK);
`ifdef TF_BURST_EN
    if (state_d == S_BURST) begin
      active_s = 1'b1;
      strobe_s = (cnt_d == BURST_LAST);
    end else begin
      active_s = active_s;
      strobe_s = strobe_s;
    end
    cback_d = ~(((state_d == S_ACK) && burst_req_s) ||
                ((state_d == S_BURST) && (beat_d != 2'd3)));
    rama_d  = A[3:2] + beat_d;
`endif
    ramcs_d = '1;
    for (int b = 0; b < BANKS; b++) begin
      if (active_s && (bank_d == BANK_W'(b))) begin
        ramcs_d[4*b +: 4] = ~lanes_d;
      end else begin
        ramcs_d[4*b +: 4] = 4'b1111;
      end
    end
    ramoe_d = ~(active_s & rd_d);
    sterm_d = ~strobe_s;
  end

  // State and output registers.
  // A reset or AS20 going high returns everything to idle immediately.
  always_ff @(posedge CLKCPU or negedge arst_n_s) begin
    if (!arst_n_s) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      bank_q  <= {BANK_W{1'b0}};
      lanes_q <= 4'b0000;
      rd_q    <= 1'b0;
      ramcs_q <= '1;
      ramoe_q <= 1'b1;
      sterm_q <= 1'b1;
`ifdef TF_BURST_EN
      beat_q  <= 2'd0;
      rama_q  <= 2'd0;
      cback_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      lanes_q <= lanes_d;
      rd_q    <= rd_d;
      ramcs_q <= ramcs_d;
      ramoe_q <= ramoe_d;
      sterm_q <= sterm_d;
`ifdef TF_BURST_EN
      beat_q  <= beat_d;
      rama_q  <= rama_d;
      cback_q <= cback_d;
`endif
    end
  end

endmodule

// File: tb/tb_fastram_burst_ctrl.sv
// Bench for fastram_burst_ctrl, built with BANKS=2, WAIT_WS=1 and BURST_WS=0.
// Each STERM beat's expected values are queued when a cycle is driven.
// The monitor pops and compares them whenever STERM is seen low.
module tb_fastram_burst_ctrl;
  localparam int WAIT_WS  = 1;
  localparam int BURST_WS = 0;
`ifdef TF_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b0;
  logic        AS20   = 1'b1;
  logic        DS20   = 1'b1;
  logic        RW20   = 1'b1;
  logic [31:0] A      = 32'h0;
  logic [1:0]  SIZ    = 2'b00;
  logic        DECODE = 1'b1;
  logic        CBREQ  = 1'b1;
  logic        CBACK, STERM, CIIN, INTCYCLE, RAMOE;
  logic [7:0]  RAMCS;
  logic [1:0]  RAMA;

  typedef struct {
    int         cyc;
    logic [1:0] rama;
    logic       cback;
    logic [7:0] cs;
    logic       oe;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   extra  = 0;

  fastram_burst_ctrl #(
    .BANKS(2), .BANK_LSB(21), .WAIT_WS(WAIT_WS), .BURST_WS(BURST_WS), .CACHEABLE(1)
  ) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20), .A(A),
    .SIZ(SIZ), .DECODE(DECODE), .CBREQ(CBREQ), .CBACK(CBACK), .STERM(STERM),
    .CIIN(CIIN), .INTCYCLE(INTCYCLE), .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMA(RAMA)
  );

  always #5 CLKCPU = ~CLKCPU;

  always @(posedge CLKCPU) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Compare every STERM beat against the oldest queued expectation.
  always @(negedge CLKCPU) begin
    if (RESET && (STERM === 1'b0)) begin
      if (sb.size() == 0) begin
        extra++;
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sterm_cyc", cyc, e.cyc);
        check("rama", {30'h0, RAMA}, {30'h0, e.rama});
        check("cback", {31'h0, CBACK}, {31'h0, e.cback});
        check("ramcs", {24'h0, RAMCS}, {24'h0, e.cs});
        check("ramoe", {31'h0, RAMOE}, {31'h0, e.oe});
      end
    end
  end

  task automatic push_beats(input logic [31:0] a, input int nb, input logic acc,
                            input logic [7:0] cs, input logic oe, input int start);
    exp_t       e;
    logic [1:0] base;
    base = a[3:2];
    for (int i = 0; i < nb; i++) begin
      e.cyc   = start + WAIT_WS + i * (BURST_WS + 1);
      e.rama  = BURST_BUILD ? (base + 2'(i)) : base;
      e.cback = !(acc && (i <= 2));
      e.cs    = cs;
      e.oe    = oe;
      sb.push_back(e);
    end
  endtask

  // One CPU cycle.
  // cut is the beat count if a burst is accepted: CBREQ is negated during that beat.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] siz, input logic rw,
                         input logic cbreq, input int cut, input logic [7:0] cs);
    logic acc;
    int   nb, start, len;
    @(negedge CLKCPU);
    acc   = BURST_BUILD && !cbreq && rw && (siz == 2'b00);
    nb    = acc ? cut : 1;
    start = cyc + 1;
    push_beats(a, nb, acc, cs, !rw, start);
    A = a; SIZ = siz; RW20 = rw; CBREQ = cbreq; DECODE = 1'b0; AS20 = 1'b0; DS20 = 1'b0;
    #1 check("intcycle_own", {31'h0, INTCYCLE}, 32'h0);
    len = WAIT_WS + (nb - 1) * (BURST_WS + 1) + 2;
    for (int c = 0; c < len; c++) begin
      @(negedge CLKCPU);
      if (acc && (cut < 4) && (cyc == start + WAIT_WS + cut - 1)) CBREQ = 1'b1;
    end
    check("done_cs", {24'h0, RAMCS}, 32'hFF);
    check("done_sterm", {31'h0, STERM}, 32'h1);
    check("done_cback", {31'h0, CBACK}, 32'h1);
    check("sb_left", sb.size(), 32'h0);
    check("extra_sterm", extra, 32'h0);
    AS20 = 1'b1; DS20 = 1'b1; DECODE = 1'b1; CBREQ = 1'b1;
    @(negedge CLKCPU);
  endtask

  // Drop AS20 after k beats.
  // Then run an outside-window cycle, which must stay untouched.
  task automatic abort_txn(input logic [31:0] a, input logic cbreq, input int k);
    logic acc;
    int   nb, kk, start, target;
    @(negedge CLKCPU);
    acc    = BURST_BUILD && !cbreq;
    nb     = acc ? 4 : 1;
    kk     = (k < nb) ? k : nb;
    start  = cyc + 1;
    target = (kk == 0) ? start : start + WAIT_WS + (kk - 1) * (BURST_WS + 1);
    push_beats(a, kk, acc, 8'hF0, 1'b0, start);
    A = a; SIZ = 2'b00; RW20 = 1'b1; CBREQ = cbreq; DECODE = 1'b0; AS20 = 1'b0; DS20 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLKCPU);
      if (cyc >= target) break;
    end
    #2 AS20 = 1'b1; DS20 = 1'b1;
    #1;
    check("abort_cs", {24'h0, RAMCS}, 32'hFF);
    check("abort_sterm", {31'h0, STERM}, 32'h1);
    check("abort_oe", {31'h0, RAMOE}, 32'h1);
    check("abort_cback", {31'h0, CBACK}, 32'h1);
    check("abort_sb", sb.size(), 32'h0);
    @(negedge CLKCPU);
    DECODE = 1'b1; CBREQ = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
    #1 check("intcycle_ext", {31'h0, INTCYCLE}, 32'h1);
    repeat (4) @(negedge CLKCPU);
    check("ext_cs", {24'h0, RAMCS}, 32'hFF);
    check("ext_sterm", extra, 32'h0);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with an active-looking cycle on the bus
    AS20 = 1'b0; DS20 = 1'b0; DECODE = 1'b0; RW20 = 1'b1; A = 32'h0800_0004;
    repeat (3) @(negedge CLKCPU);
    check("rst_cs", {24'h0, RAMCS}, 32'hFF);
    check("rst_sterm", {31'h0, STERM}, 32'h1);
    check("rst_cback", {31'h0, CBACK}, 32'h1);
    check("rst_oe", {31'h0, RAMOE}, 32'h1);
    AS20 = 1'b1; DS20 = 1'b1; DECODE = 1'b1;
    @(negedge CLKCPU);
    RESET = 1'b1;
    @(negedge CLKCPU);
    A = 32'h0800_000C;
    #1;
    check("idle_rama", {30'h0, RAMA}, 32'h3);
    check("ciin", {31'h0, CIIN}, 32'h1);

    // Single-beat reads and writes across both banks
    run_txn(32'h0800_0004, 2'b00, 1'b1, 1'b1, 1, 8'hF0);
    run_txn(32'h0800_0002, 2'b01, 1'b0, 1'b1, 1, 8'hFD);
    run_txn(32'h0800_0003, 2'b10, 1'b0, 1'b1, 1, 8'hFE);
    run_txn(32'h0820_0001, 2'b11, 1'b0, 1'b1, 1, 8'h8F);
    run_txn(32'h0820_0000, 2'b00, 1'b0, 1'b1, 1, 8'h0F);
    run_txn(32'h0820_0010, 2'b00, 1'b1, 1'b1, 1, 8'h0F);
    // Burst requests: full, wrapping, cut short, and two that must not burst
    run_txn(32'h0800_0008, 2'b00, 1'b1, 1'b0, 4, 8'hF0);
    run_txn(32'h0820_000C, 2'b00, 1'b1, 1'b0, 4, 8'h0F);
    run_txn(32'h0800_0004, 2'b00, 1'b1, 1'b0, 2, 8'hF0);
    run_txn(32'h0800_0004, 2'b01, 1'b1, 1'b0, 4, 8'hF0);
    run_txn(32'h0800_0000, 2'b00, 1'b0, 1'b0, 4, 8'hF0);
    // Asynchronous aborts: one during the wait state, one mid-burst
    abort_txn(32'h0800_0004, 1'b1, 0);
    abort_txn(32'h0800_0008, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
